// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared constants, state encoding and character helpers for the FIFO
// round-robin link scheduler.
package fifo_sched_pkg;

    localparam int         C_FLAG_BIT = 8;
    localparam logic [7:0] C_EOP      = 8'h00;
    localparam logic [7:0] C_EEP      = 8'h01;

    typedef enum logic [1:0] {IDLE, XFER, TRUNC, DRAIN} t_sched_state;

    // A character closes a packet when it is a control character carrying
    // either the normal or the error end-of-packet code.
    function automatic logic is_end_marker(input logic [8:0] chr);
        return chr[C_FLAG_BIT] && ((chr[7:0] == C_EOP) || (chr[7:0] == C_EEP));
    endfunction

endpackage

// File: rtl/fifo_rr_scheduler_rr_pick.sv
// Combinational round-robin search: first asserted request at or after
// the start index, wrapping modulo N (N need not be a power of two).
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest hit wins last.
    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Packet-aware round-robin scheduler: grants one source FIFO per packet,
// streams it to the link transmitter, and truncates over-long packets
// with an EEP before draining their remainder.
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int G_NUM_CH          = 4,
    parameter int G_DATA_WIDTH_BITS = 9,
    parameter int G_MAX_PKT_LEN     = 256
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              enable,
    input  logic [G_NUM_CH-1:0]                               src_empty,
    input  logic [G_NUM_CH*G_DATA_WIDTH_BITS-1:0]             src_data,
    output logic [G_NUM_CH-1:0]                               src_rd_en,
    output logic                                              tx_valid,
    output logic [G_DATA_WIDTH_BITS-1:0]                      tx_data,
    input  logic                                              tx_ready,
    output logic                                              busy,
    output logic [((G_NUM_CH > 1) ? $clog2(G_NUM_CH) : 1)-1:0] grant_id,
    output logic                                              err_trunc
);

    localparam int GW = (G_NUM_CH > 1) ? $clog2(G_NUM_CH) : 1;
    localparam int CW = $clog2(G_MAX_PKT_LEN + 1);
    localparam int W  = G_DATA_WIDTH_BITS;
    localparam logic [W-1:0] EEP_CHAR = W'({1'b1, C_EEP});

    t_sched_state  state;
    logic [GW-1:0] last_grant;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] cnt_inc;
    logic [W-1:0]  tx_data_q;
    logic [W-1:0]  gnt_char;
    logic [W-1:0]  cur_char;
    logic [GW-1:0] rr_start;
    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic          gnt_is_end;

    assign gnt_char   = src_data[int'(grant_id)*W +: W];
    assign gnt_is_end = is_end_marker(gnt_char[8:0]);
    assign cnt_inc    = pkt_cnt + 1'b1;
    assign busy       = (state != IDLE);
    assign rr_start   = (last_grant == GW'(G_NUM_CH - 1)) ? '0 : last_grant + 1'b1;

    rr_pick #(.N(G_NUM_CH), .IW(GW)) u_pick (
        .req   (~src_empty),
        .start (rr_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Datapath: forward the granted head, inject EEP, or silently pop on drain.
    always_comb begin
        tx_valid  = 1'b0;
        cur_char  = gnt_char;
        src_rd_en = '0;
        case (state)
            XFER: begin
                tx_valid            = ~src_empty[grant_id];
                src_rd_en[grant_id] = ~src_empty[grant_id] & tx_ready;
            end
            TRUNC: begin
                tx_valid = 1'b1;
                cur_char = EEP_CHAR;
            end
            DRAIN: src_rd_en[grant_id] = ~src_empty[grant_id];
            default: ;
        endcase
    end

    // tx_data keeps the last offered character while nothing is valid.
    assign tx_data = tx_valid ? cur_char : tx_data_q;

    // Packet-level control: grant, count, truncate, drain back to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= GW'(G_NUM_CH - 1);
            pkt_cnt    <= '0;
            err_trunc  <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            err_trunc <= 1'b0;
            if (tx_valid) tx_data_q <= cur_char;
            case (state)
                IDLE: begin
                    if (enable && pick_found) begin
                        grant_id <= pick_idx;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (tx_valid && tx_ready) begin
                        if (gnt_is_end) begin
                            state      <= IDLE;
                            last_grant <= grant_id;
                            pkt_cnt    <= '0;
                        end else begin
                            // Count includes this character; stop one short
                            // of the limit so the EEP still fits.
                            pkt_cnt <= cnt_inc;
                            if (cnt_inc == CW'(G_MAX_PKT_LEN - 1)) state <= TRUNC;
                        end
                    end
                end
                TRUNC: begin
                    if (tx_ready) begin
                        state     <= DRAIN;
                        err_trunc <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!src_empty[grant_id] && gnt_is_end) begin
                        state      <= IDLE;
                        last_grant <= grant_id;
                        pkt_cnt    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: queue-based source FIFOs, per-channel
// expected output streams and a round-robin grant predictor.
module tb_fifo_rr_scheduler;

    localparam int NCH = 4;
    localparam int W   = 9;
    localparam int MAX = 8;
    localparam int GW  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic [NCH-1:0]     src_empty;
    logic [NCH*W-1:0]   src_data;
    logic [NCH-1:0]     src_rd_en;
    logic               tx_valid;
    logic [W-1:0]       tx_data;
    logic               tx_ready;
    logic               busy;
    logic [GW-1:0]      grant_id;
    logic               err_trunc;

    always #5 clk = ~clk;

    fifo_rr_scheduler #(
        .G_NUM_CH(NCH), .G_DATA_WIDTH_BITS(W), .G_MAX_PKT_LEN(MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .src_empty(src_empty), .src_data(src_data), .src_rd_en(src_rd_en),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy), .grant_id(grant_id), .err_trunc(err_trunc)
    );

    logic [W-1:0] src_q[NCH][$];
    logic [W:0]   exp_q[NCH][$];   // bit W marks a scheduler-injected EEP
    logic [W-1:0] pkt[$];
    int           gseq[$];

    int checks = 0, errors = 0;
    int rdy_mode = 0, rdy_ph = 0;
    int exp_trunc = 0, obs_trunc = 0;
    int m_last = NCH - 1, exp_gnt = 0;
    bit prev_elig = 0, prev_dis = 0, prev_hold = 0, pend_trunc = 0;
    logic [W-1:0]   prev_d = '0;
    logic [NCH-1:0] rd_s = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic void refresh();
        for (int c = 0; c < NCH; c++) begin
            src_empty[c]        = (src_q[c].size() == 0);
            src_data[c*W +: W]  = src_empty[c] ? '0 : src_q[c][0];
        end
    endfunction

    // First non-empty channel strictly after 'last', wrapping.
    function automatic int winner(input int last);
        int j;
        for (int k = 1; k <= NCH; k++) begin
            j = (last + k) % NCH;
            if (!src_empty[j]) return j;
        end
        return -1;
    endfunction

    // Build pkt: nd data chars (optional flag-1 pass-through at mid), then end code.
    task automatic mk_pkt(input int nd, input logic [7:0] endc, input int mid);
        pkt.delete();
        for (int i = 0; i < nd; i++) begin
            if (i == mid) pkt.push_back({1'b1, 8'h05});
            else          pkt.push_back({1'b0, 8'($urandom)});
        end
        pkt.push_back({1'b1, endc});
    endtask

    // Expected link output for pkt: stops at the end marker, or after
    // MAX-1 ordinary characters followed by an injected EEP.
    task automatic add_exp(input int ch);
        int n;
        logic [W-1:0] c;
        n = 0;
        foreach (pkt[i]) begin
            c = pkt[i];
            exp_q[ch].push_back({1'b0, c});
            if (c[8] && c[7:0] <= 8'h01) break;
            n++;
            if (n == MAX - 1) begin
                exp_q[ch].push_back({1'b1, 1'b1, 8'h01});
                exp_trunc++;
                break;
            end
        end
    endtask

    task automatic load(input int ch, input int from, input int to);
        for (int i = from; i < to; i++) src_q[ch].push_back(pkt[i]);
        refresh();
    endtask

    task automatic monitor();
        logic [NCH-1:0] oh;
        logic [W:0]     e;
        oh = '0;
        oh[grant_id] = 1'b1;
        rd_s = src_rd_en;
        if (prev_elig) begin
            chk("grant_rise", 32'(busy), 1);
            if (busy) begin
                chk("grant_id", 32'(grant_id), 32'(exp_gnt));
                gseq.push_back(int'(grant_id));
                m_last = exp_gnt;
            end
        end
        if (prev_dis) chk("no_grant", 32'(busy), 0);
        chk("err_trunc", 32'(err_trunc), 32'(pend_trunc));
        if (err_trunc) obs_trunc++;
        pend_trunc = 0;
        if (prev_hold) begin
            chk("hold_valid", 32'(tx_valid), 1);
            chk("hold_data", 32'(tx_data), 32'(prev_d));
        end
        if (!busy) chk("idle_out", 32'({tx_valid, src_rd_en}), 0);
        else if ((src_rd_en & ~oh) != '0) chk("rd_other", 32'(src_rd_en), 32'(oh));
        if (tx_valid && tx_ready) begin
            if (exp_q[grant_id].size() == 0) chk("beat_expected", 0, 1);
            else begin
                e = exp_q[grant_id].pop_front();
                chk("tx_data", 32'(tx_data), 32'(e[W-1:0]));
                chk("rd_accept", 32'(src_rd_en), e[W] ? 32'(0) : 32'(oh));
                pend_trunc = e[W];
            end
        end else if (tx_valid && src_rd_en != '0) chk("rd_noaccept", 32'(src_rd_en), 0);
        prev_hold = tx_valid && !tx_ready;
        prev_d    = tx_data;
        prev_elig = !busy && enable && (src_empty != '1);
        prev_dis  = !busy && !enable;
        if (prev_elig) exp_gnt = winner(m_last);
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++)
            if (rd_s[c]) begin
                if (src_q[c].size() == 0) chk("rd_on_empty", 32'(c), 32'hffff);
                else void'(src_q[c].pop_front());
            end
        case (rdy_mode)
            1:       tx_ready = ($urandom_range(0, 2) != 0);
            2:       tx_ready = (rdy_ph % 3 == 0);
            default: tx_ready = 1'b1;
        endcase
        rdy_ph++;
        refresh();
    endtask

    function automatic bit all_empty();
        for (int c = 0; c < NCH; c++)
            if (src_q[c].size() != 0 || exp_q[c].size() != 0) return 0;
        return 1;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget && !(all_empty() && !busy)) begin
            step();
            n++;
        end
        chk(tag, 32'(n < budget), 1);
    endtask

    task automatic wait_busy(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget && !busy) begin
            step();
            n++;
        end
        chk(tag, 32'(busy), 1);
    endtask

    function automatic int gtail(input int back);
        if (gseq.size() <= back) return -1;
        return gseq[gseq.size() - 1 - back];
    endfunction

    // Asserted away from the clock edge; outputs must clear at once.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
        chk({tag, "_rd_en"}, 32'(src_rd_en), 0);
        chk({tag, "_tx_data"}, 32'(tx_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"}, 32'(err_trunc), 0);
        chk({tag, "_gid"}, 32'(grant_id), 0);
        for (int c = 0; c < NCH; c++) begin
            src_q[c].delete();
            exp_q[c].delete();
        end
        m_last = NCH - 1;
        prev_elig = 0; prev_dis = 0; prev_hold = 0; pend_trunc = 0;
        rd_s = '0;
        gseq.delete();
        refresh();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int g0, t0;
        rst_n = 1'b0; enable = 1'b0; tx_ready = 1'b1;
        refresh();
        repeat (2) @(posedge clk);
        #1;
        do_reset("rst");
        enable = 1'b1;

        // 1: single packet on ch0
        mk_pkt(3, 8'h00, -1); add_exp(0); load(0, 0, pkt.size());
        wait_done("t1_done", 50);
        chk("t1_gnt", 32'(gtail(0)), 0);

        // 2: fairness between ch0 and ch2 from a fresh pointer
        do_reset("rst2");
        for (int p = 0; p < 2; p++) begin
            mk_pkt(1, 8'h00, -1); add_exp(0); load(0, 0, pkt.size());
            mk_pkt(1, 8'h00, -1); add_exp(2); load(2, 0, pkt.size());
        end
        wait_done("t2_done", 60);
        chk("t2_g0", 32'(gtail(3)), 0);
        chk("t2_g1", 32'(gtail(2)), 2);
        chk("t2_g2", 32'(gtail(1)), 0);
        chk("t2_g3", 32'(gtail(0)), 2);

        // 3: backpressure 1,0,0,...
        rdy_mode = 2; rdy_ph = 0;
        mk_pkt(3, 8'h00, -1); add_exp(1); load(1, 0, pkt.size());
        wait_done("t3_done", 80);
        rdy_mode = 0;

        // 4: truncation on ch1, then an intact packet on ch3
        t0 = obs_trunc;
        mk_pkt(12, 8'h00, -1); add_exp(1); load(1, 0, pkt.size());
        wait_busy("t4_busy", 10);
        mk_pkt(2, 8'h00, -1); add_exp(3); load(3, 0, pkt.size());
        wait_done("t4_done", 80);
        chk("t4_trunc", 32'(obs_trunc - t0), 1);
        chk("t4_g_last", 32'(gtail(0)), 3);

        // 5: pass-through code, FIFO gap, enable dropped mid-packet
        mk_pkt(4, 8'h01, 1); add_exp(2); load(2, 0, 2);
        wait_busy("t5_busy", 10);
        repeat (6) step();
        chk("t5_hold_busy", 32'(busy), 1);
        chk("t5_hold_gid", 32'(grant_id), 2);
        enable = 1'b0;
        load(2, 2, pkt.size());
        mk_pkt(2, 8'h00, -1); add_exp(0); load(0, 0, pkt.size());
        mk_pkt(2, 8'h00, -1); add_exp(3); load(3, 0, pkt.size());
        repeat (15) step();
        chk("t5_starve_busy", 32'(busy), 0);
        chk("t5_pending", 32'(src_q[0].size() > 0), 1);
        chk("t5_ch2_done", 32'(exp_q[2].size()), 0);
        enable = 1'b1;
        wait_done("t5_done", 60);
        chk("t5_g_a", 32'(gtail(1)), 3);
        chk("t5_g_b", 32'(gtail(0)), 0);

        // 6: reset in the middle of a transfer
        mk_pkt(5, 8'h00, -1); add_exp(2); load(2, 0, pkt.size());
        wait_busy("t6_busy", 10);
        step(); step();
        do_reset("t6_rst");
        mk_pkt(1, 8'h00, -1); add_exp(1); load(1, 0, pkt.size());
        mk_pkt(1, 8'h00, -1); add_exp(0); load(0, 0, pkt.size());
        wait_done("t6_done", 40);
        chk("t6_first", 32'(gtail(1)), 0);
        chk("t6_second", 32'(gtail(0)), 1);

        // Random traffic, random ready and enable
        rdy_mode = 1;
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                g0 = $urandom_range(0, NCH - 1);
                mk_pkt($urandom_range(0, 12), ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00,
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1);
                add_exp(g0);
                load(g0, 0, pkt.size());
            end
            enable = ($urandom_range(0, 9) != 0);
            step();
        end
        enable = 1'b1;
        wait_done("rand_done", 5000);
        chk("trunc_total", 32'(obs_trunc), 32'(exp_trunc));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
